// File: rtl/tp84_snd_mixer.sv
`timescale 1ns/1ps
// tp84_snd_mixer: four-channel mixer (3x SN76489 + sample DAC) feeding the
// Time Pilot '84 IIR low-pass. Each output period (DIV clocks) latches all
// inputs, runs one shared multiplier over the four channels, shifts,
// saturates and presents one signed 16-bit sample with a one-cycle strobe.
// Optional build macro: TP84_MIX_DCBLOCK_EN adds a one-pole DC-removal stage
// in the SAT step (same latency in both builds).
module tp84_snd_mixer #(
  parameter int DIV   = 73,
  parameter int SHIFT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         ch0,
  input  logic [7:0]         ch1,
  input  logic [7:0]         ch2,
  input  logic [7:0]         ch3,
  input  logic [7:0]         gain0,
  input  logic [7:0]         gain1,
  input  logic [7:0]         gain2,
  input  logic [7:0]         gain3,
  input  logic [3:0]         mute,
  output logic signed [15:0] out,
  output logic               out_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_SAT, S_OUT
  } state_t;

  localparam logic [9:0] DIV_LAST = 10'(DIV - 1);

  state_t             state, state_next;
  logic [9:0]         div_cnt;
  logic [7:0]         ch_in   [4];
  logic [7:0]         gain_in [4];
  logic [7:0]         ch_sh   [4];
  logic [7:0]         gain_sh [4];
  logic [3:0]         mute_sh;
  logic signed [19:0] acc;
  logic signed [15:0] stage;
  logic               latch_en, mac_en, sat_en, out_en;
  logic [1:0]         mac_idx;
  logic signed [8:0]  cen_val, gain_val;
  logic signed [17:0] prod;
  logic signed [19:0] addend;
  logic signed [19:0] y_shift;
  logic signed [15:0] y_sat, y_final;

  assign ch_in[0]   = ch0;
  assign ch_in[1]   = ch1;
  assign ch_in[2]   = ch2;
  assign ch_in[3]   = ch3;
  assign gain_in[0] = gain0;
  assign gain_in[1] = gain1;
  assign gain_in[2] = gain2;
  assign gain_in[3] = gain3;

  function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
    if (v > 24'sd32767)
      return 16'sh7fff;
    else if (v < -24'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  // Output-period divider; a new sample sequence starts whenever it reads 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      div_cnt <= '0;
    else if (div_cnt == DIV_LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 10'd1;
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state: one pass IDLE -> MAC0..3 -> SAT -> OUT -> IDLE per period
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (div_cnt == '0) state_next = S_MAC0;
      S_MAC0:  state_next = S_MAC1;
      S_MAC1:  state_next = S_MAC2;
      S_MAC2:  state_next = S_MAC3;
      S_MAC3:  state_next = S_SAT;
      S_SAT:   state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Control decode: which datapath step is active and which channel to multiply
  always_comb begin
    latch_en = 1'b0;
    mac_en   = 1'b0;
    sat_en   = 1'b0;
    out_en   = 1'b0;
    mac_idx  = 2'd0;
    case (state)
      S_IDLE: latch_en = (div_cnt == '0);
      S_MAC0: begin mac_en = 1'b1; mac_idx = 2'd0; end
      S_MAC1: begin mac_en = 1'b1; mac_idx = 2'd1; end
      S_MAC2: begin mac_en = 1'b1; mac_idx = 2'd2; end
      S_MAC3: begin mac_en = 1'b1; mac_idx = 2'd3; end
      S_SAT:  sat_en = 1'b1;
      S_OUT:  out_en = 1'b1;
      default: ;
    endcase
  end

  // Shadow copy of all inputs so mid-sequence input changes cannot leak in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        ch_sh[i]   <= 8'd0;
        gain_sh[i] <= 8'd0;
      end
      mute_sh <= 4'd0;
    end else if (latch_en) begin
      for (int i = 0; i < 4; i++) begin
        ch_sh[i]   <= ch_in[i];
        gain_sh[i] <= gain_in[i];
      end
      mute_sh <= mute;
    end
  end

  // Shared multiplier: centre the selected channel around 128 and scale it
  always_comb begin
    cen_val  = $signed({1'b0, ch_sh[mac_idx]}) - 9'sd128;
    gain_val = $signed({1'b0, gain_sh[mac_idx]});
    prod     = cen_val * gain_val;
    addend   = mute_sh[mac_idx] ? 20'sd0 : $signed({{2{prod[17]}}, prod});
  end

  // Accumulator: cleared at the latch, one product added per MAC step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      acc <= '0;
    else if (latch_en)
      acc <= '0;
    else if (mac_en)
      acc <= acc + addend;
  end

  // Scale and clamp the mixed sum to the 16-bit output range
  always_comb begin
    y_shift = acc >>> SHIFT;
    y_sat   = sat16($signed({{4{y_shift[19]}}, y_shift}));
  end

`ifdef TP84_MIX_DCBLOCK_EN
  logic signed [23:0] est;
  logic signed [23:0] est_d;
  logic signed [23:0] dc_diff;

  // DC removal: subtract est/256 and let est integrate the difference
  always_comb begin
    est_d   = est >>> 8;
    dc_diff = $signed({{8{y_sat[15]}}, y_sat}) - est_d;
    y_final = sat16(dc_diff);
  end

  // DC estimate integrator, advanced once per sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      est <= '0;
    else if (sat_en)
      est <= est + dc_diff;
  end
`else
  assign y_final = y_sat;
`endif

  // Staging register written in SAT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stage <= '0;
    else if (sat_en)
      stage <= y_final;
  end

  // Output register and one-cycle strobe; out holds between strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_en;
      if (out_en)
        out <= stage;
    end
  end

endmodule

// File: tb/tb_tp84_snd_mixer.sv
`timescale 1ns/1ps
// Self-checking bench for tp84_snd_mixer: randomized inputs against a
// behavioural mixing model, plus directed literal and timing checks.
module tb_tp84_snd_mixer;

  localparam int DIV   = 73;
  localparam int SHIFT = 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [7:0]         ch0, ch1, ch2, ch3;
  logic [7:0]         gain0, gain1, gain2, gain3;
  logic [3:0]         mute;
  logic signed [15:0] out;
  logic               out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tp84_snd_mixer #(.DIV(DIV), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain3(gain3),
    .mute(mute), .out(out), .out_valid(out_valid)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat16m(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Mixed sample from the rules: sum of (ch-128)*gain over unmuted channels
  function automatic int mix_model(input int c0, input int c1, input int c2, input int c3,
                                   input int g0, input int g1, input int g2, input int g3,
                                   input int m);
    int c[4];
    int g[4];
    int s;
    c = '{c0, c1, c2, c3};
    g = '{g0, g1, g2, g3};
    s = 0;
    for (int n = 0; n < 4; n++)
      if (((m >> n) & 1) == 0)
        s += (c[n] - 128) * g[n];
    return sat16m(s >>> SHIFT);
  endfunction

  // Scoreboard: samples due at an edge index counted from reset release
  typedef struct { int due; int val; } pend_t;
  pend_t  pend_q[$];
  int     ecount   = -1;
  int     last_out = 0;
  longint est      = 0;

  always @(posedge clk) begin
    int y;
    int dd;
    bit exp_v;
    #1;
    if (!reset) begin
      pend_q.delete();
      ecount   = -1;
      last_out = 0;
      est      = 0;
      check("reset_out", out, 0);
      check("reset_valid", out_valid, 0);
    end else begin
      ecount++;
      if (ecount % DIV == 0) begin
        y = mix_model(ch0, ch1, ch2, ch3, gain0, gain1, gain2, gain3, mute);
`ifdef TP84_MIX_DCBLOCK_EN
        dd  = y - int'(est >>> 8);
        est = est + dd;
        y   = sat16m(dd);
`else
        dd = 0;
`endif
        pend_q.push_back('{ecount + 6, y});
      end
      exp_v = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == ecount) begin
        last_out = pend_q[0].val;
        exp_v    = 1'b1;
        void'(pend_q.pop_front());
      end
      check("model_valid", out_valid, exp_v);
      check("model_out", out, last_out);
    end
  end

  task automatic set_inputs(input int c0, input int c1, input int c2, input int c3,
                            input int g, input int m);
    ch0 = 8'(c0); ch1 = 8'(c1); ch2 = 8'(c2); ch3 = 8'(c3);
    gain0 = 8'(g); gain1 = 8'(g); gain2 = 8'(g); gain3 = 8'(g);
    mute = 4'(m);
  endtask

  task automatic rand_inputs();
    ch0 = 8'($urandom); ch1 = 8'($urandom); ch2 = 8'($urandom); ch3 = 8'($urandom);
    gain0 = 8'($urandom); gain1 = 8'($urandom); gain2 = 8'($urandom); gain3 = 8'($urandom);
    mute = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
  endtask

  // Wait for the next strobe; returns number of rising edges waited
  task automatic wait_strobe(output int cycles);
    cycles = 0;
    while (cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
      if (out_valid) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL strobe_timeout: got no out_valid, expected one within 300 cycles");
  endtask

  // Hold inputs long enough that the next strobe uses them, then compare
  task automatic literal_test(input string name, input int c0, input int c1,
                              input int c2, input int c3, input int g, input int m,
                              input int exp);
    int cyc;
    @(negedge clk);
    set_inputs(c0, c1, c2, c3, g, m);
    repeat (DIV + 8) @(negedge clk);
    wait_strobe(cyc);
    check(name, out, exp);
  endtask

  initial begin
    int cyc;
    set_inputs(128, 128, 128, 128, 255, 0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // First strobe lands on the 7th rising edge after release
    wait_strobe(cyc);
    check("first_strobe_edge", cyc, 7);
    check("midscale_first", out, 0);
    wait_strobe(cyc);
    check("strobe_period", cyc, DIV);
    check("midscale_second", out, 0);
    @(posedge clk); #1;
    check("strobe_width", out_valid, 0);

    // Randomized mixing against the model
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      rand_inputs();
    end

`ifndef TP84_MIX_DCBLOCK_EN
    literal_test("midscale", 128, 128, 128, 128, 255, 0, 0);
    literal_test("single_ch0", 255, 128, 128, 128, 255, 0, 16192);
    literal_test("single_ch0_muted", 255, 128, 128, 128, 255, 1, 0);
    literal_test("sat_pos", 255, 255, 255, 255, 255, 0, 32767);
    literal_test("sat_neg", 0, 0, 0, 0, 255, 0, -32768);
    literal_test("single_ch0_again", 255, 128, 128, 128, 255, 0, 16192);

    // Change ch0 two edges after the latch: sample in flight is unaffected
    repeat (DIV - 6) @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ch0 = 8'd0;
    wait_strobe(cyc);
    check("midseq_change", out, 16192);
`endif

    // Reset three edges into a sequence: partial sample is dropped
    @(negedge clk);
    set_inputs(255, 128, 128, 128, 255, 0);
    repeat (DIV + 8) @(negedge clk);
    wait_strobe(cyc);
    repeat (DIV - 6) @(posedge clk);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_reset_out", out, 0);
    check("async_reset_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_strobe(cyc);
    check("restart_strobe_edge", cyc, 7);
    check("restart_sample1", out, 16192);
`ifdef TP84_MIX_DCBLOCK_EN
    wait_strobe(cyc);
    check("dc_sample2", out, 16129);
`endif

    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
